t07_fsm_game: RTL and testbench

Top-level game-state FSM for the defusal game. It owns the MENU/PLAY/LOST/WON state, a per-second countdown and a strike counter. It sits directly upstream of the playing-state FSM, which consumes `game_state_out` as its `game_state_in`. It consumes that FSM's `game_clear` level to declare a win.

---
 rtl/t07_fsm_game.sv | 100 ++++++++++
 tb/tb_t07_fsm_game.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/t07_fsm_game.sv
// Top-level game-state FSM for the defusal game: MENU/PLAY/LOST/WON sequencing,
// per-second countdown and strike counting.
module t07_fsm_game #(
  parameter int TICK_DIV    = 10_000_000,
  parameter int TIME_INIT   = 300,
  parameter int MAX_STRIKES = 3
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       strobe,
  input  logic [5:0] button,
  input  logic       game_clear,
  input  logic       strike_pulse,
  output logic [2:0] game_state_out,
  output logic [9:0] time_left,
  output logic [1:0] strikes,
  output logic       sec_tick
);

  localparam int PW = $clog2(TICK_DIV);

  localparam logic [2:0] MENU = 3'd0;
  localparam logic [2:0] PLAY = 3'd1;
  localparam logic [2:0] LOST = 3'd2;
  localparam logic [2:0] WON  = 3'd3;

  localparam logic [9:0]    TIME_START   = 10'(TIME_INIT);
  localparam logic [1:0]    STRIKE_LIMIT = 2'(MAX_STRIKES);
  localparam logic [PW-1:0] PRESC_LAST   = PW'(TICK_DIV - 1);

  localparam logic [5:0] BTN_SELECT = 6'b000001;
  localparam logic [5:0] BTN_BACK   = 6'b100000;

  logic [2:0]    state;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_next;
  logic [9:0]    time_next;
  logic [1:0]    strikes_next;
  logic          press_select;
  logic          press_back;
  logic          wrap;

  assign game_state_out = state;

  // Next-values feed both the counter registers and the PLAY exit decision.
  always_comb begin
    press_select = strobe && (button == BTN_SELECT);
    press_back   = strobe && (button == BTN_BACK);
    wrap         = (presc == PRESC_LAST);
    presc_next   = wrap ? '0 : presc + PW'(1);
    time_next    = (wrap && (time_left != '0)) ? time_left - 10'd1 : time_left;
    strikes_next = (strike_pulse && (strikes != STRIKE_LIMIT)) ? strikes + 2'd1 : strikes;
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      state     <= MENU;
      time_left <= TIME_START;
      strikes   <= '0;
      presc     <= '0;
      sec_tick  <= 1'b0;
    end else begin
      sec_tick <= 1'b0;
      case (state)
        MENU: begin
          time_left <= TIME_START;
          strikes   <= '0;
          presc     <= '0;
          if (press_select) state <= PLAY;
        end
        PLAY: begin
          sec_tick  <= wrap;
          presc     <= presc_next;
          time_left <= time_next;
          strikes   <= strikes_next;
          if (game_clear)
            state <= WON;
          else if ((strikes_next == STRIKE_LIMIT) || (time_next == '0))
            state <= LOST;
        end
        LOST, WON: begin
          presc <= '0;
          // Counters are reloaded on the exit edge so MENU shows fresh values at once.
          if (press_select || press_back) begin
            state     <= MENU;
            time_left <= TIME_START;
            strikes   <= '0;
          end
        end
        default: begin
          state     <= MENU;
          time_left <= TIME_START;
          strikes   <= '0;
          presc     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_t07_fsm_game.sv
// Directed bench for t07_fsm_game with TICK_DIV=4, TIME_INIT=3, MAX_STRIKES=3.
module tb_t07_fsm_game;

  logic       clk;
  logic       nrst;
  logic       strobe;
  logic [5:0] button;
  logic       game_clear;
  logic       strike_pulse;
  logic [2:0] game_state_out;
  logic [9:0] time_left;
  logic [1:0] strikes;
  logic       sec_tick;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] SEL  = 6'b000001;
  localparam logic [5:0] UP   = 6'b000010;
  localparam logic [5:0] BACK = 6'b100000;
  localparam logic [5:0] NONE = 6'b000000;

  t07_fsm_game #(.TICK_DIV(4), .TIME_INIT(3), .MAX_STRIKES(3)) dut (
    .clk(clk),
    .nrst(nrst),
    .strobe(strobe),
    .button(button),
    .game_clear(game_clear),
    .strike_pulse(strike_pulse),
    .game_state_out(game_state_out),
    .time_left(time_left),
    .strikes(strikes),
    .sec_tick(sec_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       stb;
    logic [5:0] btn;
    logic       clr;
    logic       spk;
    logic [2:0] e_state;
    logic [9:0] e_time;
    logic [1:0] e_strikes;
    logic       e_tick;
  } vec_t;

  vec_t vecs[21];

  // Drive one cycle of inputs, clock once, then sample #1 after the edge.
  task automatic step(input string name, input logic rst, input logic stb, input logic [5:0] btn,
                      input logic clr, input logic spk, input logic [2:0] es,
                      input logic [9:0] et, input logic [1:0] ek, input logic etk);
    nrst = rst; strobe = stb; button = btn; game_clear = clr; strike_pulse = spk;
    @(posedge clk);
    #1;
    checks++;
    if (game_state_out !== es || time_left !== et || strikes !== ek || sec_tick !== etk) begin
      errors++;
      $display("FAIL %s: got state=%0d time=%0d strikes=%0d tick=%0d, expected state=%0d time=%0d strikes=%0d tick=%0d",
               name, game_state_out, time_left, strikes, sec_tick, es, et, ek, etk);
    end
  endtask

  task automatic idle(input string name, input logic [2:0] es, input logic [9:0] et,
                      input logic [1:0] ek, input logic etk);
    step(name, 1'b0, 1'b0, NONE, 1'b0, 1'b0, es, et, ek, etk);
  endtask

  initial begin
    nrst = 1'b1; strobe = 1'b0; button = NONE; game_clear = 1'b0; strike_pulse = 1'b0;

    //           rst   stb   btn          clr   spk   state time  stk   tick
    vecs[0]  = '{1'b1, 1'b0, NONE,        1'b0, 1'b0, 3'd0, 10'd3, 2'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, NONE,        1'b0, 1'b0, 3'd0, 10'd3, 2'd0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 6'b000011,   1'b0, 1'b0, 3'd0, 10'd3, 2'd0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, NONE,        1'b0, 1'b1, 3'd0, 10'd3, 2'd0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, SEL,         1'b0, 1'b0, 3'd1, 10'd3, 2'd0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, NONE,        1'b0, 1'b0, 3'd1, 10'd3, 2'd0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, NONE,        1'b0, 1'b0, 3'd1, 10'd3, 2'd0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, NONE,        1'b0, 1'b0, 3'd1, 10'd3, 2'd0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, NONE,        1'b0, 1'b0, 3'd1, 10'd2, 2'd0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, BACK,        1'b0, 1'b0, 3'd1, 10'd2, 2'd0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, SEL,         1'b0, 1'b0, 3'd1, 10'd2, 2'd0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, NONE,        1'b0, 1'b0, 3'd1, 10'd2, 2'd0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, NONE,        1'b0, 1'b0, 3'd1, 10'd1, 2'd0, 1'b1};
    vecs[13] = '{1'b0, 1'b0, NONE,        1'b0, 1'b0, 3'd1, 10'd1, 2'd0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, NONE,        1'b0, 1'b0, 3'd1, 10'd1, 2'd0, 1'b0};
    vecs[15] = '{1'b0, 1'b0, NONE,        1'b0, 1'b0, 3'd1, 10'd1, 2'd0, 1'b0};
    vecs[16] = '{1'b0, 1'b0, NONE,        1'b0, 1'b0, 3'd2, 10'd0, 2'd0, 1'b1};
    vecs[17] = '{1'b0, 1'b0, NONE,        1'b0, 1'b1, 3'd2, 10'd0, 2'd0, 1'b0};
    vecs[18] = '{1'b0, 1'b0, NONE,        1'b1, 1'b0, 3'd2, 10'd0, 2'd0, 1'b0};
    vecs[19] = '{1'b0, 1'b1, UP,          1'b0, 1'b0, 3'd2, 10'd0, 2'd0, 1'b0};
    vecs[20] = '{1'b0, 1'b1, SEL,         1'b0, 1'b0, 3'd0, 10'd3, 2'd0, 1'b0};

    for (int i = 0; i < 21; i++) begin
      step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].stb, vecs[i].btn, vecs[i].clr,
           vecs[i].spk, vecs[i].e_state, vecs[i].e_time, vecs[i].e_strikes, vecs[i].e_tick);
    end

    // Three strikes lose the game; a further pulse cannot push past the limit.
    step("s2_enter", 1'b0, 1'b1, SEL, 1'b0, 1'b0, 3'd1, 10'd3, 2'd0, 1'b0);
    step("s2_strike1", 1'b0, 1'b0, NONE, 1'b0, 1'b1, 3'd1, 10'd3, 2'd1, 1'b0);
    step("s2_strike2", 1'b0, 1'b0, NONE, 1'b0, 1'b1, 3'd1, 10'd3, 2'd2, 1'b0);
    step("s2_strike3", 1'b0, 1'b0, NONE, 1'b0, 1'b1, 3'd2, 10'd3, 2'd3, 1'b0);
    step("s2_strike4", 1'b0, 1'b0, NONE, 1'b0, 1'b1, 3'd2, 10'd3, 2'd3, 1'b0);
    step("s2_exit", 1'b0, 1'b1, SEL, 1'b0, 1'b0, 3'd0, 10'd3, 2'd0, 1'b0);

    // game_clear on the final tick wins; WON ignores UP, BACK returns to MENU.
    step("s3_enter", 1'b0, 1'b1, SEL, 1'b0, 1'b0, 3'd1, 10'd3, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) idle("s3_wait_a", 3'd1, 10'd3, 2'd0, 1'b0);
    idle("s3_tick_a", 3'd1, 10'd2, 2'd0, 1'b1);
    for (int i = 0; i < 3; i++) idle("s3_wait_b", 3'd1, 10'd2, 2'd0, 1'b0);
    idle("s3_tick_b", 3'd1, 10'd1, 2'd0, 1'b1);
    for (int i = 0; i < 3; i++) idle("s3_wait_c", 3'd1, 10'd1, 2'd0, 1'b0);
    step("s3_win_on_tick", 1'b0, 1'b0, NONE, 1'b1, 1'b0, 3'd3, 10'd0, 2'd0, 1'b1);
    step("s4_won_up", 1'b0, 1'b1, UP, 1'b0, 1'b0, 3'd3, 10'd0, 2'd0, 1'b0);
    step("s4_won_back", 1'b0, 1'b1, BACK, 1'b0, 1'b0, 3'd0, 10'd3, 2'd0, 1'b0);
    step("s4_menu_strike", 1'b0, 1'b0, NONE, 1'b0, 1'b1, 3'd0, 10'd3, 2'd0, 1'b0);

    // Reset mid-PLAY overrides a simultaneous SELECT press.
    step("s5_enter", 1'b0, 1'b1, SEL, 1'b0, 1'b0, 3'd1, 10'd3, 2'd0, 1'b0);
    step("s5_strike", 1'b0, 1'b0, NONE, 1'b0, 1'b1, 3'd1, 10'd3, 2'd1, 1'b0);
    for (int i = 0; i < 2; i++) idle("s5_wait", 3'd1, 10'd3, 2'd1, 1'b0);
    idle("s5_tick", 3'd1, 10'd2, 2'd1, 1'b1);
    step("s5_reset_sel", 1'b1, 1'b1, SEL, 1'b0, 1'b0, 3'd0, 10'd3, 2'd0, 1'b0);

    // Strike coincident with tick; then final strike together with game_clear wins.
    step("s6_enter", 1'b0, 1'b1, SEL, 1'b0, 1'b0, 3'd1, 10'd3, 2'd0, 1'b0);
    for (int i = 0; i < 3; i++) idle("s6_wait", 3'd1, 10'd3, 2'd0, 1'b0);
    step("s6_strike_tick", 1'b0, 1'b0, NONE, 1'b0, 1'b1, 3'd1, 10'd2, 2'd1, 1'b1);
    step("s6_strike2", 1'b0, 1'b0, NONE, 1'b0, 1'b1, 3'd1, 10'd2, 2'd2, 1'b0);
    step("s6_strike3_clear", 1'b0, 1'b0, NONE, 1'b1, 1'b1, 3'd3, 10'd2, 2'd3, 1'b0);
    step("s6_exit", 1'b0, 1'b1, SEL, 1'b0, 1'b0, 3'd0, 10'd3, 2'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
